// File: rtl/seq_detector_fsm.sv
// Serial sequence detector: flags when the last PAT_W accepted bits equal a runtime-loadable
// pattern. Moore/Mealy timing and overlapping/non-overlapping detection chosen at elaboration.
module seq_detector_fsm #(
   parameter int unsigned      PAT_W     = 4,
   parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011),
   parameter bit               MEALY     = 1'b0,
   parameter bit               OVERLAP   = 1'b1,
   parameter int unsigned      CNT_W     = 8
) (
   input  logic             clk,
   input  logic             Resetn,
   input  logic             en,
   input  logic             w,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic             clr_count,
   output logic             z,
   output logic [CNT_W-1:0] match_count,
   output logic             filled
);

   localparam int unsigned      FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              z_q, z_d;
   logic [PAT_W-1:0]  window;
   logic              hit;

   assign window = {hist_q, w};

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      cnt_d  = cnt_q;
      hit    = en & ~load & Resetn & (fill_q == FILL_MAX) & (window == pat_q);
      z_d    = hit;
      if (load) begin
         // Pattern change invalidates history; the bit presented this cycle is dropped.
         pat_d  = pattern_in;
         fill_d = '0;
      end else if (en) begin
         hist_d = window[PAT_W-2:0];
         if (hit && !OVERLAP) begin
            fill_d = '0;
         end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
      end
      if (clr_count) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!Resetn) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= RESET_PAT;
         cnt_q  <= '0;
         z_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         cnt_q  <= cnt_d;
         z_q    <= z_d;
      end
   end

   assign z           = MEALY ? hit : z_q;
   assign match_count = cnt_q;
   assign filled      = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Bench for seq_detector_fsm: four configurations share one stimulus stream and are checked
// against a queue-based model, a constant vector table and directed corner-case sequences.
module tb_seq_detector_fsm;

   typedef bit bq_t[$];

   typedef struct {
      bit en;
      bit w;
      bit mz_ov;
      bit mz_nov;
      bit ez;
      int c_ov;
      int c_nov;
   } vec_t;

   logic       clk = 1'b0;
   logic       Resetn, en, w, load, clr_count;
   logic [3:0] pattern_in;
   logic       z0, z1, z2, z3, f0, f1, f2, f3;
   logic [7:0] cnt0, cnt1, cnt2;
   logic [1:0] cnt3;

   int checks   = 0;
   int failures = 0;

   // Model state: accepted bits since the history was last invalidated, oldest first.
   bq_t        qo, qn;
   logic [3:0] mpat;
   bit         zq_o, zq_n;
   int         cnt_o, cnt_n;

   always #5 clk = ~clk;

   seq_detector_fsm #(.MEALY(1'b0), .OVERLAP(1'b1)) u_moore_ov (
      .clk(clk), .Resetn(Resetn), .en(en), .w(w), .load(load), .pattern_in(pattern_in),
      .clr_count(clr_count), .z(z0), .match_count(cnt0), .filled(f0));

   seq_detector_fsm #(.MEALY(1'b0), .OVERLAP(1'b0)) u_moore_nov (
      .clk(clk), .Resetn(Resetn), .en(en), .w(w), .load(load), .pattern_in(pattern_in),
      .clr_count(clr_count), .z(z1), .match_count(cnt1), .filled(f1));

   seq_detector_fsm #(.MEALY(1'b1), .OVERLAP(1'b1)) u_mealy_ov (
      .clk(clk), .Resetn(Resetn), .en(en), .w(w), .load(load), .pattern_in(pattern_in),
      .clr_count(clr_count), .z(z2), .match_count(cnt2), .filled(f2));

   seq_detector_fsm #(.MEALY(1'b0), .OVERLAP(1'b1), .CNT_W(2)) u_cnt2 (
      .clk(clk), .Resetn(Resetn), .en(en), .w(w), .load(load), .pattern_in(pattern_in),
      .clr_count(clr_count), .z(z3), .match_count(cnt3), .filled(f3));

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input int m);
      return (c > m) ? m : c;
   endfunction

   function automatic bit mhit(input bq_t q, input logic [3:0] p, input logic wb);
      int n = q.size();
      if (n < 3) return 1'b0;
      return {q[n-3], q[n-2], q[n-1], wb} == p;
   endfunction

   task automatic apply(input bit r, input bit e, input bit wb, input bit ld,
                        input logic [3:0] p, input bit c);
      Resetn     = r;
      en         = e;
      w          = wb;
      load       = ld;
      pattern_in = p;
      clr_count  = c;
      #1;
   endtask

   // Compare every output against the model, then clock once and advance the model.
   task automatic tick();
      bit ho, hn;
      ho = Resetn && en && !load && mhit(qo, mpat, w);
      hn = Resetn && en && !load && mhit(qn, mpat, w);
      chk("moore_ov_z", z0, zq_o);
      chk("moore_nov_z", z1, zq_n);
      chk("mealy_z", z2, ho);
      chk("cntw2_z", z3, zq_o);
      chk("cnt_ov", cnt0, sat(cnt_o, 255));
      chk("cnt_nov", cnt1, sat(cnt_n, 255));
      chk("cnt_mealy", cnt2, sat(cnt_o, 255));
      chk("cnt_w2", cnt3, sat(cnt_o, 3));
      chk("filled_ov", f0, qo.size() >= 3);
      chk("filled_nov", f1, qn.size() >= 3);
      chk("filled_mealy", f2, qo.size() >= 3);
      @(posedge clk);
      if (!Resetn) begin
         qo.delete();
         qn.delete();
         mpat  = 4'b1011;
         zq_o  = 1'b0;
         zq_n  = 1'b0;
         cnt_o = 0;
         cnt_n = 0;
      end else begin
         zq_o = ho;
         zq_n = hn;
         if (load) begin
            mpat = pattern_in;
            qo.delete();
            qn.delete();
         end else if (en) begin
            qo.push_back(w);
            qn.push_back(w);
            if (hn) qn.delete();
            while (qo.size() > 3) void'(qo.pop_front());
            while (qn.size() > 3) void'(qn.pop_front());
         end
         if (clr_count) begin
            cnt_o = 0;
            cnt_n = 0;
         end else begin
            if (ho) cnt_o++;
            if (hn) cnt_n++;
         end
      end
      #1;
   endtask

   task automatic bit_in(input bit wb);
      apply(1'b1, 1'b1, wb, 1'b0, 4'b0000, 1'b0);
      tick();
   endtask

   task automatic do_reset();
      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      tick();
   endtask

   vec_t tbl[9];

   initial begin
      // Stream 1,0,1,1,0,1,1 then two idle cycles; values observed before each edge.
      tbl[0] = '{1, 1, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 0, 0, 0, 0};
      tbl[2] = '{1, 1, 0, 0, 0, 0, 0};
      tbl[3] = '{1, 1, 0, 0, 1, 0, 0};
      tbl[4] = '{1, 0, 1, 1, 0, 1, 1};
      tbl[5] = '{1, 1, 0, 0, 0, 1, 1};
      tbl[6] = '{1, 1, 0, 0, 1, 1, 1};
      tbl[7] = '{0, 0, 1, 0, 0, 2, 1};
      tbl[8] = '{0, 1, 0, 0, 0, 2, 1};

      apply(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      qo.delete();
      qn.delete();
      mpat  = 4'b1011;
      zq_o  = 1'b0;
      zq_n  = 1'b0;
      cnt_o = 0;
      cnt_n = 0;
      do_reset();
      chk("reset_count", cnt0, 0);
      chk("reset_z", z0, 0);

      for (int i = 0; i < 9; i++) begin
         apply(1'b1, tbl[i].en, tbl[i].w, 1'b0, 4'b0000, 1'b0);
         chk("tbl_moore_ov", z0, tbl[i].mz_ov);
         chk("tbl_moore_nov", z1, tbl[i].mz_nov);
         chk("tbl_mealy", z2, tbl[i].ez);
         chk("tbl_cnt_ov", cnt0, tbl[i].c_ov);
         chk("tbl_cnt_nov", cnt1, tbl[i].c_nov);
         tick();
      end

      // en gaps: toggling w while en=0 must not enter the history.
      do_reset();
      bit_in(1'b1);
      bit_in(1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, i[0], 1'b0, 4'b0000, 1'b0);
         tick();
      end
      bit_in(1'b1);
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("gap_mealy_hit", z2, 1);
      tick();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      chk("gap_moore_pulse", z0, 1);
      chk("gap_count", cnt0, 1);
      tick();

      // Load mid-stream: the would-be completing bit is dropped and history restarts.
      do_reset();
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
      apply(1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 1'b0);
      chk("load_suppress", z2, 0);
      tick();
      bit_in(1'b1);
      bit_in(1'b1);
      bit_in(1'b0);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
      chk("load_mealy_hit", z2, 1);
      tick();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      chk("load_moore_pulse", z0, 1);
      chk("load_count", cnt0, 1);
      tick();

      // Reset mid-sequence discards the partial 101.
      do_reset();
      bit_in(1'b1);
      bit_in(1'b0);
      bit_in(1'b1);
      apply(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("rst_mealy_zero", z2, 0);
      tick();
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("rst_fresh_nohit", z2, 0);
      chk("rst_count", cnt0, 0);
      tick();
      bit_in(1'b0);
      bit_in(1'b1);
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("rst_fourth_hit", z2, 1);
      tick();

      // Saturation with CNT_W=2 and clr_count priority over a simultaneous hit.
      do_reset();
      apply(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) bit_in(1'b1);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
      chk("sat_w2", cnt3, 3);
      chk("sat_w8", cnt0, 7);
      tick();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      chk("clr_w2", cnt3, 0);
      tick();
      apply(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      chk("clr_hit_mealy", z2, 1);
      tick();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      chk("clr_wins_w2", cnt3, 0);
      chk("clr_wins_w8", cnt0, 0);
      tick();

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         apply($urandom_range(0, 99) >= 2, $urandom_range(0, 3) != 0, 1'($urandom),
               $urandom_range(0, 99) < 3, 4'($urandom), $urandom_range(0, 99) < 3);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
